io_uart_regs: RTL

Memory-mapped IO responder for the CPU's IO store/load port: the 0xC000_xxxx region driven by the memory-access stage via `dma_io_we/wadr/wdata/radr`, returning `dma_io_rdata`. It holds a byte-wide TX FIFO, an 8N1 serial transmitter, a baud divisor register and an LED register. It sits beside the data RAM at the top level and is the target end of the IO bus.

---
 rtl/io_uart_pkg.sv | 29 ++
 rtl/io_uart_regs_if.sv | 30 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/io_uart_regs.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// Shared definitions for the IO UART register block.
// Contents: register word offsets (adr[15:2]), STATUS bit positions, and the
// transmitter FSM state encoding.
package io_uart_pkg;

    // Word offsets on the IO bus (adr[15:2]).
    localparam logic [13:0] AdrTxdata = 14'h0000;
    localparam logic [13:0] AdrStatus = 14'h0001;
    localparam logic [13:0] AdrBaud   = 14'h0002;
    localparam logic [13:0] AdrLed    = 14'h0003;

    // STATUS register fields.
    localparam int unsigned StatusBusy   = 0;
    localparam int unsigned StatusFull   = 1;
    localparam int unsigned StatusEmpty  = 2;
    localparam int unsigned StatusOvf    = 3;
    localparam int unsigned StatusCntLsb = 4;

    // Smallest legal baud divisor; smaller writes are clamped to this.
    localparam logic [15:0] BaudMin = 16'd2;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/io_uart_regs_if.sv
// IO store/load bus between the memory-access stage (master) and the IO
// responder (slave).
// Signals: dma_io_we write strobe, dma_io_wadr/dma_io_wdata write word address
// and data, dma_io_radr read word address (valid every cycle, no strobe),
// dma_io_rdata registered read data.
interface io_uart_regs_if;

    logic        dma_io_we;
    logic [15:2] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [15:2] dma_io_radr;
    logic [31:0] dma_io_rdata;

    modport master (
        output dma_io_we,
        output dma_io_wadr,
        output dma_io_wdata,
        output dma_io_radr,
        input  dma_io_rdata
    );

    modport slave (
        input  dma_io_we,
        input  dma_io_wadr,
        input  dma_io_wdata,
        input  dma_io_radr,
        output dma_io_rdata
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output.
// Ports: clk, rst_n (async, active-low); push/wdata enqueue; pop dequeues the
// head shown on rdata; full, empty and count (0..2**AddrWidth) report fill.
// A push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned Width     = 8,
    parameter int unsigned AddrWidth = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [Width-1:0]     wdata,
    input  logic                 pop,
    output logic [Width-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic [AddrWidth:0]   count
);

    localparam int unsigned Depth = 2 ** AddrWidth;

    logic [Width-1:0]     mem_q [Depth];
    logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrWidth:0]   count_q, count_d;
    logic                 push_ok, pop_ok;

    assign full    = (count_q == (AddrWidth + 1)'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    // When full, the slot being written is the one being popped this cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AddrWidth + 1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AddrWidth + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/io_uart_regs.sv
// Memory-mapped IO responder: TX FIFO, 8N1 transmitter, baud divisor and LED
// register on the CPU IO bus.
// Ports: clk, rst_n (async, active-low); bus (IO bus slave); uart_tx serial
// output, idles high; led LED register output.
module io_uart_regs
    import io_uart_pkg::*;
#(
    parameter int unsigned FIFO_AW      = 3,
    parameter logic [15:0] BAUD_DEFAULT = 16'd868
) (
    input  logic                 clk,
    input  logic                 rst_n,
    io_uart_regs_if.slave        bus,
    output logic                 uart_tx,
    output logic [2:0]           led
);

    logic        wr_txdata, wr_status, wr_baud, wr_led;
    logic [15:0] baud_q;
    logic [2:0]  led_q;
    logic        overflow_q;
    logic [31:0] rdata_q, rdata_d;

    logic [7:0]       fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [FIFO_AW:0] fifo_count;

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] bit_div_q, bit_div_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        bit_end;

    logic [15:0] unused_wdata;
    assign unused_wdata = bus.dma_io_wdata[31:16];

    assign wr_txdata = bus.dma_io_we && (bus.dma_io_wadr == AdrTxdata);
    assign wr_status = bus.dma_io_we && (bus.dma_io_wadr == AdrStatus);
    assign wr_baud   = bus.dma_io_we && (bus.dma_io_wadr == AdrBaud);
    assign wr_led    = bus.dma_io_we && (bus.dma_io_wadr == AdrLed);

    sync_fifo #(
        .Width     (8),
        .AddrWidth (FIFO_AW)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_txdata),
        .wdata (bus.dma_io_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Read mux; registered so data appears one cycle after the address.
    always_comb begin
        rdata_d = '0;
        case (bus.dma_io_radr)
            AdrStatus: begin
                rdata_d[StatusBusy]         = (state_q != StIdle);
                rdata_d[StatusFull]         = fifo_full;
                rdata_d[StatusEmpty]        = fifo_empty;
                rdata_d[StatusOvf]          = overflow_q;
                rdata_d[StatusCntLsb +: 4]  = 4'(fifo_count);
            end
            AdrBaud:  rdata_d[15:0] = baud_q;
            AdrLed:   rdata_d[2:0]  = led_q;
            default:  rdata_d       = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q     <= BAUD_DEFAULT;
            led_q      <= '0;
            overflow_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rdata_q <= rdata_d;
            if (wr_baud) begin
                baud_q <= (bus.dma_io_wdata[15:0] < BaudMin) ? BaudMin : bus.dma_io_wdata[15:0];
            end
            if (wr_led) led_q <= bus.dma_io_wdata[2:0];
            if (wr_txdata && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end else if (wr_status && bus.dma_io_wdata[StatusOvf]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bit_end = (baud_cnt_q == bit_div_q - 16'd1);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_div_d = bit_div_q;
        bit_idx_d = bit_idx_q;
        fifo_pop  = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (fifo_pop) begin
            shift_d   = fifo_rdata;
            bit_div_d = baud_q;
            bit_idx_d = '0;
        end

        if (state_q == StIdle || bit_end) begin
            baud_cnt_d = '0;
        end else begin
            baud_cnt_d = baud_cnt_q + 16'd1;
        end

        // Line level follows the next state so uart_tx changes on the same edge.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_div_q  <= BAUD_DEFAULT;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_div_q  <= bit_div_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
        end
    end

    assign bus.dma_io_rdata = rdata_q;
    assign uart_tx          = tx_q;
    assign led              = led_q;

endmodule
